// File: rtl/iter_div_responder.sv
// Multi-cycle radix-2 restoring divider, responder end of the EXE divide handshake.
// Produces {quotient, remainder} WIDTH+1 cycles after acceptance; cancel aborts an op in flight.
module iter_div_responder #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               div_signed,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic               cancel,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata,
  output logic               m_axis_dout_tvalid
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic [2*WIDTH-1:0] dout_q, dout_d;

  logic               accept;
  logic               dvd_neg, dsr_neg;
  logic [WIDTH:0]     partial, diff;
  logic               ge;
  logic [WIDTH-1:0]   step_rem, step_quo, fix_quo, fix_rem;

  // Partial remainder stays below the divisor, so a WIDTH+1-bit subtract
  // yields a correct sign bit.
  always_comb begin
    partial  = {rem_q, dvd_q[WIDTH-1]};
    diff     = partial - {1'b0, dsr_q};
    ge       = ~diff[WIDTH];
    step_rem = ge ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    step_quo = {dvd_q[WIDTH-2:0], ge};
    // Negating |dividend| restores the raw dividend, which covers divide-by-zero too.
    fix_quo  = dz_q ? '1 : (neg_quo_q ? -step_quo : step_quo);
    fix_rem  = neg_rem_q ? -step_rem : step_rem;
  end

  assign dvd_neg = div_signed & s_axis_dividend_tdata[WIDTH-1];
  assign dsr_neg = div_signed & s_axis_divisor_tdata[WIDTH-1];
  assign accept  = (state_q == IDLE) & s_axis_divisor_tvalid & s_axis_dividend_tvalid & ~cancel;

  // NOTE: every _d gets its hold value first, so no path through the case leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    dsr_d     = dsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    dout_d    = dout_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = CALC;
          cnt_d     = '0;
          rem_d     = '0;
          dvd_d     = dvd_neg ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
          dsr_d     = dsr_neg ? -s_axis_divisor_tdata : s_axis_divisor_tdata;
          neg_quo_d = dvd_neg ^ dsr_neg;
          neg_rem_d = dvd_neg;
          dz_d      = (s_axis_divisor_tdata == '0);
        end
      end
      CALC: begin
        if (cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          rem_d = step_rem;
          dvd_d = step_quo;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = DONE;
            cnt_d   = '0;
            dout_d  = {fix_quo, fix_rem};
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      rem_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      rem_q     <= rem_d;
      dsr_q     <= dsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      dout_q    <= dout_d;
    end
  end

  assign s_axis_divisor_tready  = (state_q == IDLE);
  assign s_axis_dividend_tready = (state_q == IDLE);
  assign m_axis_dout_tdata      = dout_q;
  // A flush arriving in the DONE cycle suppresses the pulse in that same cycle.
  assign m_axis_dout_tvalid     = (state_q == DONE) & ~cancel;

endmodule
